ex_div_unit: RTL and testbench

//  Multi-cycle radix-2 integer divider in the Ex stage; executes DIV/DIVU/REM/REMU issued by De2 (DivOpEn).

---
 rtl/ex_div_unit.sv | 148 ++++++++++++++
 tb/tb_ex_div_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU in the Ex stage; one quotient bit per CALC cycle.
// Optional macro DIV_EARLY_OUT_EN finishes |dividend| < |divisor| ops at accept time.
module ex_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic            RemSel,
    input  logic            S1Sign,
    input  logic            S2Sign,
    input  logic [XLEN-1:0] DeS1,
    input  logic [XLEN-1:0] DeS2,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    // Handshake: an op is taken when Start=1, Flush=0 and the unit is in IDLE or DONE;
    // Busy tells upstream to hold, Done is a one-cycle pulse that qualifies Result.
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t            state;
    state_t            nextState;
    logic [XLEN:0]     remReg;
    logic [XLEN-1:0]   quoReg;
    logic [XLEN-1:0]   divisorReg;
    logic [CNT_W-1:0]  count;
    logic              qNeg;
    logic              rNeg;
    logic              remSelReg;
    logic [XLEN-1:0]   resultReg;
    logic              busyReg;
    logic              doneReg;

    logic [XLEN-1:0]   absS1;
    logic [XLEN-1:0]   absS2;
    logic              divZero;
    logic              overflow;
    logic              earlyOut;
    logic              special;
    logic              accept;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic              borrow;
    logic [XLEN-1:0]   qFix;
    logic [XLEN-1:0]   rFix;

    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

    assign absS1    = (S1Sign && DeS1[XLEN-1]) ? -DeS1 : DeS1;
    assign absS2    = (S2Sign && DeS2[XLEN-1]) ? -DeS2 : DeS2;
    assign divZero  = (DeS2 == '0);
    assign overflow = S1Sign & S2Sign & (DeS1 == SIGNED_MIN) & (&DeS2);
`ifdef DIV_EARLY_OUT_EN
    assign earlyOut = ~divZero & (absS1 < absS2);
`else
    assign earlyOut = 1'b0;
`endif
    assign special  = divZero | overflow | earlyOut;
    assign accept   = Start & ~Flush & ((state == IDLE) | (state == DONE));

    // Trial subtraction; the extra top bit of diff is the borrow.
    assign shifted  = {remReg[XLEN-1:0], quoReg[XLEN-1]};
    assign diff     = shifted - {1'b0, divisorReg};
    assign borrow   = diff[XLEN];

    assign qFix     = qNeg ? -quoReg : quoReg;
    assign rFix     = rNeg ? -remReg[XLEN-1:0] : remReg[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    nextState = special ? DONE : CALC;
                end else begin
                    nextState = IDLE;
                end
            end
            CALC: begin
                if (count == '0) begin
                    nextState = FIXUP;
                end
            end
            FIXUP:   nextState = DONE;
            default: nextState = IDLE;
        endcase
        if (Flush) begin
            nextState = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            count      <= '0;
            qNeg       <= 1'b0;
            rNeg       <= 1'b0;
            remSelReg  <= 1'b0;
            resultReg  <= '0;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
        end else begin
            busyReg <= (nextState == CALC) | (nextState == FIXUP);
            doneReg <= (nextState == DONE);
            if (accept) begin
                qNeg       <= S1Sign & DeS1[XLEN-1] ^ (S2Sign & DeS2[XLEN-1]);
                rNeg       <= S1Sign & DeS1[XLEN-1];
                remSelReg  <= RemSel;
                remReg     <= '0;
                quoReg     <= absS1;
                divisorReg <= absS2;
                count      <= CNT_W'(XLEN - 1);
                if (divZero) begin
                    resultReg <= RemSel ? DeS1 : '1;
                end else if (overflow) begin
                    resultReg <= RemSel ? '0 : DeS1;
                end else if (earlyOut) begin
                    resultReg <= RemSel ? DeS1 : '0;
                end
            end else if (state == CALC && !Flush) begin
                remReg <= borrow ? shifted : diff;
                quoReg <= {quoReg[XLEN-2:0], ~borrow};
                count  <= count - 1'b1;
            end else if (state == FIXUP && !Flush) begin
                resultReg <= remSelReg ? rFix : qFix;
            end
        end
    end

    assign Busy   = busyReg;
    assign Done   = doneReg;
    assign Result = resultReg;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: arithmetic reference model, per-cycle Busy/Done/Result compare.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic        RemSel = 1'b0;
    logic        S1Sign = 1'b0;
    logic        S2Sign = 1'b0;
    logic [31:0] DeS1 = '0;
    logic [31:0] DeS2 = '0;
    logic        Flush = 1'b0;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY = 1;
`else
    localparam int EARLY = 34;
`endif

    ex_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .RemSel(RemSel),
        .S1Sign(S1Sign), .S2Sign(S2Sign), .DeS1(DeS1), .DeS2(DeS2),
        .Flush(Flush), .Busy(Busy), .Done(Done), .Result(Result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          passed = 0;
    int          expCyc_q[$];
    logic [31:0] exp_q[$];
    int          busyLo = 1;
    int          busyHi = 0;
    bit          modelOn = 0;
    bit          expDone;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic longint toLong(input bit s, input logic [31:0] v);
        return s ? longint'($signed(v)) : longint'({32'b0, v});
    endfunction

    function automatic logic [31:0] modelRes(input bit rem, input bit s1, input bit s2,
                                             input logic [31:0] a, input logic [31:0] b);
        longint av, bv, q, r;
        if (b == 0) return rem ? a : 32'hFFFF_FFFF;
        av = toLong(s1, a);
        bv = toLong(s2, b);
        q  = av / bv;
        r  = av % bv;
        return rem ? r[31:0] : q[31:0];
    endfunction

    function automatic int modelLat(input bit s1, input bit s2, input logic [31:0] a, input logic [31:0] b);
        longint av, bv;
        if (b == 0) return 1;
        av = toLong(s1, a);
        bv = toLong(s2, b);
        if (s1 && s2 && (av / bv > 64'sd2147483647)) return 1;
`ifdef DIV_EARLY_OUT_EN
        if ((av < 0 ? -av : av) < (bv < 0 ? -bv : bv)) return 1;
`endif
        return 34;
    endfunction

    always @(negedge clk) begin
        if (rst_n && modelOn) begin
            expDone = (expCyc_q.size() > 0) && (expCyc_q[0] == cyc);
            check("busy", {31'b0, Busy}, {31'b0, (cyc >= busyLo) && (cyc <= busyHi)});
            check("done", {31'b0, Done}, {31'b0, expDone});
            if (expDone) begin
                if (Done) check("result", Result, exp_q[0]);
                void'(expCyc_q.pop_front());
                void'(exp_q.pop_front());
            end
            if (Flush) begin
                expCyc_q.delete();
                exp_q.delete();
                busyHi = 0;
            end
        end
    end

    task automatic waitC(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input bit rem, input bit s1, input bit s2,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] litRes, input int litLat);
        logic [31:0] r;
        int          lat;
        bit          acc;
        r   = modelRes(rem, s1, s2, a, b);
        lat = modelLat(s1, s2, a, b);
        check({name, " model"}, r, litRes);
        check({name, " latency"}, lat, litLat);
        acc = !Flush && !((cyc >= busyLo) && (cyc <= busyHi));
        Start  = 1'b1;
        RemSel = rem;
        S1Sign = s1;
        S2Sign = s2;
        DeS1   = a;
        DeS2   = b;
        if (acc) begin
            expCyc_q.push_back(cyc + lat);
            exp_q.push_back(r);
            if (lat > 1) begin
                busyLo = cyc + 1;
                busyHi = cyc + lat - 1;
            end
        end
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'b0, Busy}, 32'd0);
        check("reset done", {31'b0, Done}, 32'd0);
        check("reset result", Result, 32'd0);
        rst_n = 1'b1;
        modelOn = 1;
        waitC(1);

        // Back-to-back chain of normal ops, each issued in the previous op's DONE cycle
        issue("divu 100/7", 0, 0, 0, 32'd100, 32'd7, 32'd14, 34);
        waitC(33);
        issue("remu 100/7", 1, 0, 0, 32'd100, 32'd7, 32'd2, 34);
        waitC(33);
        issue("div -7/2", 0, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        waitC(33);
        issue("rem -7/2", 1, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        waitC(35);

        // Single-cycle special cases, also chained DONE -> DONE
        issue("divu 5/0", 0, 0, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        issue("rem 5/0", 1, 1, 1, 32'd5, 32'd0, 32'd5, 1);
        issue("div ovf", 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue("rem ovf", 1, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        waitC(2);

        // Flush at T+10 kills the op; restart at T+11 completes at T+45
        issue("divu flushed", 0, 0, 0, 32'd100, 32'd7, 32'd14, 34);
        waitC(9);
        Flush = 1'b1;
        waitC(1);
        Flush = 1'b0;
        issue("divu restart", 0, 0, 0, 32'd100, 32'd7, 32'd14, 34);
        waitC(35);

        // Start during CALC is ignored
        issue("divu 50/5", 0, 0, 0, 32'd50, 32'd5, 32'd10, 34);
        waitC(4);
        issue("divu ignored", 0, 0, 0, 32'd9, 32'd3, 32'd3, 34);
        waitC(30);

        // Flush and Start in the same cycle: no op
        Flush = 1'b1;
        issue("flush+start", 0, 0, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        Flush = 1'b0;
        waitC(3);

        issue("divu 3/10", 0, 0, 0, 32'd3, 32'd10, 32'd0, EARLY);
        waitC(40);
        issue("remu 3/10", 1, 0, 0, 32'd3, 32'd10, 32'd3, EARLY);
        waitC(40);
        issue("divu 0/5", 0, 0, 0, 32'd0, 32'd5, 32'd0, EARLY);
        waitC(40);
        issue("div 7/-2", 0, 1, 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        waitC(40);
        issue("rem 7/-2", 1, 1, 1, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        waitC(40);
        issue("div -8/-3", 0, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 34);
        waitC(40);
        issue("rem -8/-3", 1, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 34);
        waitC(40);
        issue("divu max/1", 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
        waitC(40);

        // Reset mid-operation
        issue("divu reset", 0, 0, 0, 32'd100, 32'd7, 32'd14, 34);
        waitC(5);
        rst_n = 1'b0;
        #1;
        check("midreset busy", {31'b0, Busy}, 32'd0);
        check("midreset done", {31'b0, Done}, 32'd0);
        check("midreset result", Result, 32'd0);
        expCyc_q.delete();
        exp_q.delete();
        busyHi = 0;
        waitC(1);
        rst_n = 1'b1;
        waitC(40);

        check("drained", expCyc_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
